axis_ingress_fifo: RTL and testbench

Store-and-forward packet buffer on the 512-bit AXI-Stream ingress path, placed directly upstream of the idle/pass-through stage and feeding its slave stream. It absorbs bursts and releases only complete packets downstream, so the downstream stage never sees a partial packet. Packets longer than a configured beat limit are discarded whole. Kept and dropped packets are counted.

---
 rtl/axis_ingress_fifo_if.sv | 34 +++
 rtl/axis_ingress_fifo.sv | 179 +++++++++++++++++
 tb/tb_axis_ingress_fifo.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_ingress_fifo_if.sv
// Stream bundle for the ingress store-and-forward buffer: upstream slave stream,
// downstream master stream and the packet statistics.
interface axis_ingress_fifo_if #(
  parameter int DATA_W = 512,
  parameter int KEEP_W = 64
);
  logic              s_axis_tvalid;
  logic              s_axis_tready;
  logic [DATA_W-1:0] s_axis_tdata;
  logic [KEEP_W-1:0] s_axis_tkeep;
  logic              s_axis_tlast;

  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic [DATA_W-1:0] m_axis_tdata;
  logic [KEEP_W-1:0] m_axis_tkeep;
  logic              m_axis_tlast;

  logic [31:0]       pkt_count;
  logic [31:0]       drop_count;

  // The buffer itself is the slave of this bundle; the surrounding logic is the master.
  modport slave (
    input  s_axis_tvalid, s_axis_tdata, s_axis_tkeep, s_axis_tlast, m_axis_tready,
    output s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast,
    output pkt_count, drop_count
  );

  modport master (
    output s_axis_tvalid, s_axis_tdata, s_axis_tkeep, s_axis_tlast, m_axis_tready,
    input  s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast,
    input  pkt_count, drop_count
  );
endinterface

// File: rtl/axis_ingress_fifo.sv
// Store-and-forward AXI-Stream packet buffer: releases only complete packets and
// discards packets longer than MAX_PKT_BEATS, counting kept and dropped packets.
module axis_ingress_fifo #(
  parameter int DATA_W        = 512,
  parameter int KEEP_W        = 64,
  parameter int DEPTH         = 64,
  parameter int MAX_PKT_BEATS = 32
) (
  input  logic              clock,
  input  logic              reset,
  axis_ingress_fifo_if.slave io
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(MAX_PKT_BEATS + 2);
  localparam int MW = DATA_W + KEEP_W + 1;

  typedef enum logic {
    ST_PKT  = 1'b0,
    ST_DROP = 1'b1
  } wr_state_e;

  wr_state_e         r_state, w_state_nxt;
  logic [CW-1:0]     r_beat_cnt, w_beat_cnt_nxt, w_cnt_inc;
  logic [PW-1:0]     r_wr_ptr, r_wr_commit, r_fetch_ptr, r_rd_ptr;
  logic              w_full, w_s_ready, w_s_accept;
  logic              w_wr_en, w_commit, w_rollback;

  logic [MW-1:0]     r_mem [DEPTH];
  logic [MW-1:0]     r_rdata;
  logic              r_rd_vld, w_rd_en, w_pop;
  logic [1:0]        w_stage_cnt;
  logic [DATA_W-1:0] w_rd_data;
  logic [KEEP_W-1:0] w_rd_keep;
  logic              w_rd_last;

  logic              r_out_vld, r_out_last, r_skid_vld, r_skid_last;
  logic [DATA_W-1:0] r_out_data, r_skid_data;
  logic [KEEP_W-1:0] r_out_keep, r_skid_keep;
  logic [31:0]       r_pkt_count, r_drop_count;

  // rd_ptr only advances on the downstream handshake, so prefetched beats still count as occupied.
  assign w_full     = (r_wr_ptr - r_rd_ptr) == PW'(DEPTH);
  assign w_s_ready  = !reset && ((r_state == ST_DROP) || !w_full ||
                                 (r_beat_cnt == CW'(MAX_PKT_BEATS)));
  assign w_s_accept = io.s_axis_tvalid && w_s_ready;
  assign w_cnt_inc  = r_beat_cnt + CW'(1);

  // NOTE: every output of a combinational block gets a default first so no path infers a latch.
  always_comb begin
    w_state_nxt    = r_state;
    w_beat_cnt_nxt = r_beat_cnt;
    w_wr_en        = 1'b0;
    w_commit       = 1'b0;
    w_rollback     = 1'b0;
    case (r_state)
      ST_PKT: begin
        if (w_s_accept) begin
          if (w_cnt_inc <= CW'(MAX_PKT_BEATS)) begin
            w_wr_en = 1'b1;
            if (io.s_axis_tlast) begin
              w_commit       = 1'b1;
              w_beat_cnt_nxt = '0;
            end else begin
              w_beat_cnt_nxt = w_cnt_inc;
            end
          end else begin
            // Oversize beat: discard the uncommitted part of the packet
            w_rollback     = 1'b1;
            w_beat_cnt_nxt = '0;
            if (!io.s_axis_tlast) w_state_nxt = ST_DROP;
          end
        end
      end
      ST_DROP: begin
        if (w_s_accept && io.s_axis_tlast) w_state_nxt = ST_PKT;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= ST_PKT;
      r_beat_cnt   <= '0;
      r_wr_ptr     <= '0;
      r_wr_commit  <= '0;
      r_drop_count <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
      if (w_rollback)   r_wr_ptr <= r_wr_commit;
      else if (w_wr_en) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_commit)     r_wr_commit <= r_wr_ptr + PW'(1);
      if (w_rollback)   r_drop_count <= r_drop_count + 32'd1;
    end
  end

  // A fetch is issued only if the beat it returns next cycle is guaranteed a slot in out/skid.
  assign w_pop       = r_out_vld && io.m_axis_tready;
  assign w_stage_cnt = 2'(r_out_vld) + 2'(r_skid_vld) + 2'(r_rd_vld);
  assign w_rd_en     = (r_fetch_ptr != r_wr_commit) &&
                       ((w_stage_cnt < 2'd2) || ((w_stage_cnt == 2'd2) && w_pop));

  // NOTE: the buffer RAM and its read register have no reset; valid flags and pointers qualify them.
  always_ff @(posedge clock) begin
    if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= {io.s_axis_tdata, io.s_axis_tkeep, io.s_axis_tlast};
    if (w_rd_en) r_rdata <= r_mem[r_fetch_ptr[AW-1:0]];
  end

  assign w_rd_data = r_rdata[MW-1 -: DATA_W];
  assign w_rd_keep = r_rdata[KEEP_W:1];
  assign w_rd_last = r_rdata[0];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_fetch_ptr <= '0;
      r_rd_ptr    <= '0;
      r_rd_vld    <= 1'b0;
      r_out_vld   <= 1'b0;
      r_out_data  <= '0;
      r_out_keep  <= '0;
      r_out_last  <= 1'b0;
      r_skid_vld  <= 1'b0;
      r_skid_data <= '0;
      r_skid_keep <= '0;
      r_skid_last <= 1'b0;
      r_pkt_count <= '0;
    end else begin
      r_rd_vld <= w_rd_en;
      if (w_rd_en) r_fetch_ptr <= r_fetch_ptr + PW'(1);
      if (w_pop)   r_rd_ptr    <= r_rd_ptr + PW'(1);
      if (w_pop && r_out_last) r_pkt_count <= r_pkt_count + 32'd1;

      if (w_pop) begin
        if (r_skid_vld) begin
          r_out_data <= r_skid_data;
          r_out_keep <= r_skid_keep;
          r_out_last <= r_skid_last;
          r_skid_vld <= r_rd_vld;
          if (r_rd_vld) begin
            r_skid_data <= w_rd_data;
            r_skid_keep <= w_rd_keep;
            r_skid_last <= w_rd_last;
          end
        end else begin
          r_out_vld <= r_rd_vld;
          if (r_rd_vld) begin
            r_out_data <= w_rd_data;
            r_out_keep <= w_rd_keep;
            r_out_last <= w_rd_last;
          end
        end
      end else if (r_rd_vld) begin
        if (!r_out_vld) begin
          r_out_vld  <= 1'b1;
          r_out_data <= w_rd_data;
          r_out_keep <= w_rd_keep;
          r_out_last <= w_rd_last;
        end else begin
          r_skid_vld  <= 1'b1;
          r_skid_data <= w_rd_data;
          r_skid_keep <= w_rd_keep;
          r_skid_last <= w_rd_last;
        end
      end
    end
  end

  assign io.s_axis_tready = w_s_ready;
  assign io.m_axis_tvalid = r_out_vld;
  assign io.m_axis_tdata  = r_out_data;
  assign io.m_axis_tkeep  = r_out_keep;
  assign io.m_axis_tlast  = r_out_last;
  assign io.pkt_count     = r_pkt_count;
  assign io.drop_count    = r_drop_count;

endmodule

// File: tb/tb_axis_ingress_fifo.sv
// Directed and randomized bench for axis_ingress_fifo; expected beats are queued as
// they are accepted upstream and compared as they leave downstream.
module tb_axis_ingress_fifo;

  localparam int DATA_W = 512;
  localparam int KEEP_W = 64;
  localparam int DEPTH  = 64;
  localparam int MAX    = 32;
  localparam int BUDGET = 2000;

  typedef struct {
    logic [DATA_W-1:0] d;
    logic [KEEP_W-1:0] k;
    logic              l;
  } beat_t;

  logic  clock;
  logic  rst;
  int    total;
  int    bad;
  int    exp_pkt;
  int    exp_drop;
  int    n_popped;
  bit    g_stalled;
  bit    rnd_done;
  beat_t sb[$];

  axis_ingress_fifo_if #(.DATA_W(DATA_W), .KEEP_W(KEEP_W)) io_if ();

  axis_ingress_fifo #(
    .DATA_W(DATA_W), .KEEP_W(KEEP_W), .DEPTH(DEPTH), .MAX_PKT_BEATS(MAX)
  ) u_dut (
    .clock(clock),
    .reset(rst),
    .io   (io_if)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [639:0] obs, input logic [639:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] mk_data(input int pid, input int b);
    logic [15:0] p16;
    logic [15:0] b16;
    p16 = 16'(pid);
    b16 = 16'(b);
    return {16{p16, b16}};
  endfunction

  function automatic logic [KEEP_W-1:0] mk_keep(input int pid, input int b);
    logic [7:0] k;
    k = 8'(b * 37 + pid * 11 + 1);
    return {4{k, ~k}};
  endfunction

  // Output monitor: scoreboard pop on every handshake, hold check on every stall.
  logic [DATA_W-1:0] prev_d;
  logic [KEEP_W-1:0] prev_k;
  logic              prev_l;
  bit                prev_stall;
  beat_t             mon_e;

  always @(negedge clock) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_tvalid", io_if.m_axis_tvalid, 1'b1);
        check("hold_beat", {io_if.m_axis_tdata, io_if.m_axis_tkeep, io_if.m_axis_tlast},
              {prev_d, prev_k, prev_l});
      end
      if (io_if.m_axis_tvalid && io_if.m_axis_tready) begin
        n_popped++;
        if (sb.size() == 0) begin
          check("spurious_beat", io_if.m_axis_tvalid, 1'b0);
        end else begin
          mon_e = sb.pop_front();
          check("out_tdata", io_if.m_axis_tdata, mon_e.d);
          check("out_tkeep", io_if.m_axis_tkeep, mon_e.k);
          check("out_tlast", io_if.m_axis_tlast, mon_e.l);
        end
      end
      prev_stall = io_if.m_axis_tvalid && !io_if.m_axis_tready;
      prev_d     = io_if.m_axis_tdata;
      prev_k     = io_if.m_axis_tkeep;
      prev_l     = io_if.m_axis_tlast;
    end
  end

  // Drives one packet; each beat is held until the handshake edge has passed.
  task automatic send_pkt(input int pid, input int len, input bit gaps);
    int  waited;
    bit  taken;
    beat_t e;
    @(posedge clock);
    #1;
    for (int b = 0; b < len; b++) begin
      if (gaps) while ($urandom_range(0, 1) == 0) begin
        @(posedge clock);
        #1;
      end
      io_if.s_axis_tvalid = 1'b1;
      io_if.s_axis_tdata  = mk_data(pid, b);
      io_if.s_axis_tkeep  = mk_keep(pid, b);
      io_if.s_axis_tlast  = (b == len - 1);
      waited = 0;
      @(negedge clock);
      while (!io_if.s_axis_tready && waited < BUDGET) begin
        g_stalled = 1'b1;
        waited++;
        @(negedge clock);
      end
      taken = io_if.s_axis_tready;
      if (!taken) check("s_tready_timeout", io_if.s_axis_tready, 1'b1);
      @(posedge clock);
      #1;
      io_if.s_axis_tvalid = 1'b0;
      if (taken && len <= MAX) begin
        e.d = mk_data(pid, b);
        e.k = mk_keep(pid, b);
        e.l = (b == len - 1);
        sb.push_back(e);
      end
      if (taken && b == MAX) begin
        exp_drop++;
        check("drop_count_at_oversize", io_if.drop_count, exp_drop);
      end
    end
    if (len <= MAX) exp_pkt++;
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    @(negedge clock);
    while ((sb.size() != 0 || io_if.m_axis_tvalid) && n < BUDGET) begin
      @(negedge clock);
      n++;
    end
    check({tag, "_drained"}, sb.size(), 0);
    check({tag, "_pkt_count"}, io_if.pkt_count, exp_pkt);
    check({tag, "_drop_count"}, io_if.drop_count, exp_drop);
  endtask

  initial begin
    int base;
    int n;
    int kept;
    int len;
    total = 0; bad = 0; exp_pkt = 0; exp_drop = 0; n_popped = 0;
    g_stalled = 1'b0; rnd_done = 1'b0;
    rst = 1'b1;
    io_if.s_axis_tvalid = 1'b0;
    io_if.s_axis_tdata  = '0;
    io_if.s_axis_tkeep  = '0;
    io_if.s_axis_tlast  = 1'b0;
    io_if.m_axis_tready = 1'b1;

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    check("rst_m_tvalid", io_if.m_axis_tvalid, 1'b0);
    check("rst_s_tready", io_if.s_axis_tready, 1'b0);
    rst = 1'b0;
    @(negedge clock);
    check("post_rst_s_tready", io_if.s_axis_tready, 1'b1);
    check("post_rst_m_tvalid", io_if.m_axis_tvalid, 1'b0);
    check("post_rst_pkt_count", io_if.pkt_count, 0);
    check("post_rst_drop_count", io_if.drop_count, 0);

    // 4-beat packet: first beat visible two edges after the tlast handshake, then back-to-back
    send_pkt(0, 4, 1'b0);
    @(negedge clock);
    check("lat_edge_n", io_if.m_axis_tvalid, 1'b0);
    @(negedge clock);
    check("lat_edge_n1", io_if.m_axis_tvalid, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("burst_tvalid", io_if.m_axis_tvalid, 1'b1);
    end
    @(negedge clock);
    check("single_pkt_count", io_if.pkt_count, 1);
    check("single_idle_after", io_if.m_axis_tvalid, 1'b0);
    wait_drain("single");

    // 40-beat oversize packet then a 3-beat packet
    g_stalled = 1'b0;
    send_pkt(1, 40, 1'b0);
    check("oversize_no_stall", g_stalled, 1'b0);
    send_pkt(2, 3, 1'b0);
    wait_drain("oversize40");

    // Two 32-beat packets into a blocked output: exactly DEPTH beats fit
    io_if.m_axis_tready = 1'b0;
    g_stalled = 1'b0;
    send_pkt(3, 32, 1'b0);
    send_pkt(4, 32, 1'b0);
    check("fill_no_stall", g_stalled, 1'b0);
    io_if.s_axis_tvalid = 1'b1;
    io_if.s_axis_tdata  = mk_data(5, 0);
    io_if.s_axis_tkeep  = mk_keep(5, 0);
    io_if.s_axis_tlast  = 1'b0;
    @(negedge clock);
    check("full_s_tready", io_if.s_axis_tready, 1'b0);
    check("full_m_tvalid", io_if.m_axis_tvalid, 1'b1);
    check("full_head_data", io_if.m_axis_tdata, mk_data(3, 0));
    @(posedge clock);
    #1;
    io_if.m_axis_tready = 1'b1;
    send_pkt(5, 4, 1'b0);
    wait_drain("full64");

    // 33 beats with tlast on the oversize beat, then a normal packet and a 1-beat packet
    send_pkt(6, 33, 1'b0);
    @(negedge clock);
    check("oversize_last_s_tready", io_if.s_axis_tready, 1'b1);
    send_pkt(7, 5, 1'b0);
    send_pkt(8, 1, 1'b0);
    wait_drain("oversize33");

    // Reset while the fifth beat of a 10-beat packet is on the output
    base = n_popped;
    send_pkt(9, 10, 1'b0);
    n = 0;
    while (n_popped < base + 4 && n < BUDGET) begin
      @(posedge clock);
      n++;
    end
    check("beats_before_reset", n_popped - base, 4);
    #2;
    rst = 1'b1;
    sb.delete();
    #1;
    check("midrst_m_tvalid", io_if.m_axis_tvalid, 1'b0);
    check("midrst_m_tdata", io_if.m_axis_tdata, '0);
    check("midrst_m_tlast", io_if.m_axis_tlast, 1'b0);
    check("midrst_s_tready", io_if.s_axis_tready, 1'b0);
    check("midrst_pkt_count", io_if.pkt_count, 0);
    check("midrst_drop_count", io_if.drop_count, 0);
    @(posedge clock);
    #1;
    rst = 1'b0;
    exp_pkt  = 0;
    exp_drop = 0;
    @(negedge clock);
    check("after_midrst_s_tready", io_if.s_axis_tready, 1'b1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      check("after_midrst_empty", io_if.m_axis_tvalid, 1'b0);
    end
    check("after_midrst_pkt_count", io_if.pkt_count, 0);

    // 200 random packets of 1..40 beats with random valid gaps and downstream backpressure
    kept = 0;
    fork
      begin
        for (int p = 0; p < 200; p++) begin
          len = $urandom_range(1, 40);
          if (len <= MAX) kept++;
          send_pkt(100 + p, len, 1'b1);
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clock);
          #1;
          io_if.m_axis_tready = 1'($urandom_range(0, 1));
        end
      end
    join
    io_if.m_axis_tready = 1'b1;
    wait_drain("random");
    check("random_kept", io_if.pkt_count, kept);
    check("random_sum", io_if.pkt_count + io_if.drop_count, 200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
